// File: rtl/audio_pkg.sv
// Shared audio types: FSM state encoding and default I2S timing constants.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_BCLK_HALF = 8;
   localparam int DEF_DATA_W    = 24;
   localparam int DEF_SLOT_W    = 32;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: registered AUD_BCLK plus single-cycle rise/fall ticks.
module i2s_bclk_gen
   import audio_pkg::*;
#(
   parameter int BCLK_HALF = DEF_BCLK_HALF
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic rise,
   output logic fall,
   output logic first
);

   localparam logic [7:0] LIM = 8'(BCLK_HALF - 1);

   logic [7:0] cnt;
   logic       live;
   logic       wrap;

   // The first wrap after start acts as a fall tick with BCLK already low,
   // so bit 0 opens with a full low half-period.
   assign wrap  = run && (cnt == LIM);
   assign first = wrap && !live;
   assign rise  = wrap && live && !bclk;
   assign fall  = wrap && (bclk || !live);

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt  <= '0;
         bclk <= 1'b0;
         live <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         live <= 1'b1;
         if (live) bclk <= ~bclk;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/i2s_codec_emulator.sv
// I2S codec emulator: serializes ADC samples, deserializes DAC frames.
module i2s_codec_emulator
   import audio_pkg::*;
#(
   parameter int BCLK_HALF = DEF_BCLK_HALF,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SLOT_W    = DEF_SLOT_W
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] adc_left_in,
   input  logic [DATA_W-1:0] adc_right_in,
   output logic              adc_req,
   output logic [DATA_W-1:0] dac_left_out,
   output logic [DATA_W-1:0] dac_right_out,
   output logic              dac_valid,
   output logic              AUD_BCLK,
   output logic              AUD_ADCLRCK,
   output logic              AUD_DACLRCK,
   output logic              AUD_ADCDAT,
   input  logic              AUD_DACDAT,
   output logic              busy
);

   localparam int BW = $clog2(2 * SLOT_W);
   localparam int PW = BW - 1;
   localparam logic [BW-1:0] LAST = BW'(2 * SLOT_W - 1);
   localparam logic [PW-1:0] DPOS = PW'(DATA_W);

   state_t state, nstate;

   logic              run;
   logic              rise, fall, first;
   logic              wrap, latch, drop;
   logic [BW-1:0]     bit_cnt, nbit;
   logic [PW-1:0]     pos, np, idx;
   logic              slot, ser, lrck, in_data;
   logic [DATA_W-1:0] sh_l, sh_r, nsh;
   logic [DATA_W-1:0] sr_l, sr_r;

   i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
      .clk   (CLOCK_50),
      .reset (reset),
      .run   (run),
      .bclk  (AUD_BCLK),
      .rise  (rise),
      .fall  (fall),
      .first (first)
   );

   assign pos     = bit_cnt[PW-1:0];
   assign slot    = bit_cnt[BW-1];
   assign in_data = (pos != '0) && (pos <= DPOS);
   assign wrap    = fall && (first || bit_cnt == LAST);
   assign drop    = wrap && (nstate == IDLE);
   assign latch   = wrap && (nstate != IDLE);

   assign AUD_ADCLRCK = lrck;
   assign AUD_DACLRCK = lrck;

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (enable) nstate = RUN;
         RUN:     if (!enable) nstate = DRAIN;
         DRAIN:   if (enable) nstate = RUN;
                  else if (wrap) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      run  = busy;
   end

   // Bit that goes on AUD_ADCDAT at the coming fall tick
   always_comb begin
      nbit = first ? '0 : bit_cnt + BW'(1);
      np   = nbit[PW-1:0];
      nsh  = nbit[BW-1] ? sh_r : sh_l;
      idx  = DPOS - np;
      ser  = 1'b0;
      if (np != '0 && np <= DPOS) ser = nsh[idx];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         bit_cnt       <= '0;
         lrck          <= 1'b1;
         AUD_ADCDAT    <= 1'b0;
         sh_l          <= '0;
         sh_r          <= '0;
         sr_l          <= '0;
         sr_r          <= '0;
         dac_left_out  <= '0;
         dac_right_out <= '0;
         dac_valid     <= 1'b0;
         adc_req       <= 1'b0;
      end else begin
         adc_req   <= 1'b0;
         dac_valid <= 1'b0;
         if (!busy) begin
            bit_cnt    <= '0;
            lrck       <= 1'b1;
            AUD_ADCDAT <= 1'b0;
         end else begin
            if (fall && drop) begin
               bit_cnt    <= '0;
               lrck       <= 1'b1;
               AUD_ADCDAT <= 1'b0;
            end else if (fall) begin
               bit_cnt    <= nbit;
               lrck       <= nbit[BW-1];
               AUD_ADCDAT <= ser;
            end
            if (latch) begin
               sh_l    <= adc_left_in;
               sh_r    <= adc_right_in;
               adc_req <= 1'b1;
            end
            if (rise && in_data) begin
               if (slot) sr_r <= {sr_r[DATA_W-2:0], AUD_DACDAT};
               else      sr_l <= {sr_l[DATA_W-2:0], AUD_DACDAT};
            end
            if (rise && slot && pos == DPOS) begin
               dac_left_out  <= sr_l;
               dac_right_out <= {sr_r[DATA_W-2:0], AUD_DACDAT};
               dac_valid     <= 1'b1;
            end
         end
      end
   end

endmodule
